// File: rtl/input_layer_reader.sv
// input_layer_reader: streams INPUT_SIZE words from a synchronous-read RAM into a parallel vector.
// Define INPUT_READER_CHECKSUM_EN to add the checksum port (running sum of captured words).
module input_layer_reader #(
  parameter int unsigned INPUT_SIZE   = 784,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  output logic                                    done,
  output logic                                    inputs_read_en,
  output logic [$clog2(INPUT_SIZE)-1:0]           inputs_read_address,
  input  logic [DATA_WIDTH-1:0]                   inputs_read_data,
  output logic [INPUT_SIZE-1:0][OUTPUT_WIDTH-1:0] outputs
`ifdef INPUT_READER_CHECKSUM_EN
  ,
  output logic [OUTPUT_WIDTH+$clog2(INPUT_SIZE)-1:0] checksum
`endif
);
  localparam int unsigned AW = $clog2(INPUT_SIZE);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(INPUT_SIZE - 1);
  localparam logic [CW-1:0] FULL      = CW'(INPUT_SIZE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                                state, state_next;
  logic [CW-1:0]                         issue_cnt;
  logic [CW-1:0]                         capture_cnt;
  logic [READ_LATENCY-1:0]               pipe_valid;
  logic [READ_LATENCY-1:0][AW-1:0]       pipe_index;
  logic                                  capture;
  logic [AW-1:0]                         capture_index;
  logic                                  load_begin;

  assign capture       = pipe_valid[READ_LATENCY-1];
  assign capture_index = pipe_index[READ_LATENCY-1];
  assign load_begin    = (state == IDLE) && start;
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)                   state_next = READ;
      READ:    if (issue_cnt == LAST_ADDR)  state_next = DRAIN;
      DRAIN:   if (capture_cnt == FULL)     state_next = DONE;
      DONE:    if (!start)                  state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Strobe and address are registered from the READ state, so each issue lands one cycle after its count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt           <= '0;
      inputs_read_en      <= 1'b0;
      inputs_read_address <= '0;
    end else begin
      inputs_read_en      <= (state == READ);
      inputs_read_address <= (state == READ) ? issue_cnt[AW-1:0] : '0;
      issue_cnt           <= (state == READ) ? issue_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_index <= '0;
    end else begin
      pipe_valid[0] <= inputs_read_en;
      pipe_index[0] <= inputs_read_address;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_index[i] <= pipe_index[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outputs     <= '0;
      capture_cnt <= '0;
    end else begin
      if (load_begin)   capture_cnt <= '0;
      else if (capture) capture_cnt <= capture_cnt + 1'b1;
      if (capture) outputs[capture_index] <= OUTPUT_WIDTH'(inputs_read_data);
    end
  end

`ifdef INPUT_READER_CHECKSUM_EN
  localparam int unsigned SW = OUTPUT_WIDTH + AW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       checksum <= '0;
    else if (load_begin) checksum <= '0;
    else if (capture) checksum <= checksum + SW'(inputs_read_data);
  end
`else
  // No accumulator when the checksum port is absent.
`endif

endmodule
